// File: rtl/bus_port_fifo_pkg.sv
// bus_port_pkg: shared constants for bus_port_fifo (ID field, broadcast ID, drop-counter width)
package bus_port_pkg;
  localparam int ID_W = 8;
  localparam logic [ID_W-1:0] BCAST_ID = 8'hFF;
  localparam int DROP_CNT_W = 8;
  localparam int PKT_W_DEF = 16;
  typedef logic [PKT_W_DEF-1:0] pkt_def_t;
endpackage

// File: rtl/bus_port_fifo_if.sv
// bus_port_fifo_if: device + bus handshake bundle; slave = fifo side, master = driver side
interface bus_port_fifo_if #(parameter int PCKG_SZ = 16);
  logic dev_push;
  logic [PCKG_SZ-1:0] dev_d_in;
  logic dev_full;
  logic pndng;
  logic [PCKG_SZ-1:0] D_pop;
  logic pop;
  logic push;
  logic [PCKG_SZ-1:0] D_push;
  logic dev_pop;
  logic [PCKG_SZ-1:0] dev_d_out;
  logic dev_pndng;
  logic [1:0] ovf;
  modport slave(input dev_push, dev_d_in, pop, push, D_push, dev_pop,
                output dev_full, pndng, D_pop, dev_d_out, dev_pndng, ovf);
  modport master(output dev_push, dev_d_in, pop, push, D_push, dev_pop,
                 input dev_full, pndng, D_pop, dev_d_out, dev_pndng, ovf);
endinterface

// File: rtl/bus_port_fifo_fifo.sv
// port_fifo: FWFT circular queue (push/pop/d_in -> head/pndng/full/drop), sync active-low reset
module port_fifo #(
  parameter int W = 16,
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] d_in,
  output logic [W-1:0] head,
  output logic pndng,
  output logic full,
  output logic drop
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign pndng = cnt_q != '0;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign head = mem_q[rp_q];
  always_comb begin
    do_pop = pop && pndng;
    do_push = push && (!full || do_pop);
    drop = push && full && !pop;
    wp_d = do_push ? wp_q + AW'(1) : wp_q;
    rp_d = do_pop ? rp_q + AW'(1) : rp_q;
    cnt_d = (do_push && !do_pop) ? cnt_q + (AW+1)'(1) : (do_pop && !do_push) ? cnt_q - (AW+1)'(1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk)
    if (reset && do_push) mem_q[wp_q] <= d_in;
endmodule

// File: rtl/bus_port_fifo.sv
// bus_port_fifo: per-port TX/RX queues between a device and the bus; optional BUS_PORT_FIFO_DROP_CNT_EN adds tx/rx_drop_cnt
module bus_port_fifo
  import bus_port_pkg::*;
#(
  parameter int PCKG_SZ = 16,
  parameter int DEPTH = 8
) (
  input logic clk,
  input logic reset,
  bus_port_fifo_if.slave bp
`ifdef BUS_PORT_FIFO_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0] tx_drop_cnt,
  output logic [DROP_CNT_W-1:0] rx_drop_cnt
`endif
);
  typedef logic [PCKG_SZ-1:0] pkt_t;
  pkt_t tx_head, rx_head;
  logic tx_drop, rx_drop, rx_full;
  logic [1:0] ovf_q, ovf_d;
  port_fifo #(.W(PCKG_SZ), .DEPTH(DEPTH)) u_tx (
    .clk(clk), .reset(reset), .push(bp.dev_push), .pop(bp.pop), .d_in(bp.dev_d_in),
    .head(tx_head), .pndng(bp.pndng), .full(bp.dev_full), .drop(tx_drop)
  );
  port_fifo #(.W(PCKG_SZ), .DEPTH(DEPTH)) u_rx (
    .clk(clk), .reset(reset), .push(bp.push), .pop(bp.dev_pop), .d_in(bp.D_push),
    .head(rx_head), .pndng(bp.dev_pndng), .full(rx_full), .drop(rx_drop)
  );
  assign bp.D_pop = tx_head;
  assign bp.dev_d_out = rx_head;
  assign bp.ovf = ovf_q;
  assign ovf_d = ovf_q | {rx_drop, tx_drop};
  always_ff @(posedge clk) ovf_q <= !reset ? 2'b00 : ovf_d;
`ifdef BUS_PORT_FIFO_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  always_comb begin
    tx_cnt_d = (tx_drop && tx_cnt_q != '1) ? tx_cnt_q + DROP_CNT_W'(1) : tx_cnt_q;
    rx_cnt_d = (rx_drop && rx_cnt_q != '1) ? rx_cnt_q + DROP_CNT_W'(1) : rx_cnt_q;
  end
  always_ff @(posedge clk) begin
    tx_cnt_q <= !reset ? '0 : tx_cnt_d;
    rx_cnt_q <= !reset ? '0 : rx_cnt_d;
  end
  assign tx_drop_cnt = tx_cnt_q;
  assign rx_drop_cnt = rx_cnt_q;
`endif
endmodule

// File: tb/tb_bus_port_fifo.sv
// tb_bus_port_fifo: directed + random stimulus against a queue-based reference model
module tb_bus_port_fifo;
  localparam int W = 16;
  localparam int D = 8;
  logic clk = 0;
  logic reset;
  bus_port_fifo_if #(.PCKG_SZ(W)) bp ();
`ifdef BUS_PORT_FIFO_DROP_CNT_EN
  logic [7:0] tx_drop_cnt, rx_drop_cnt;
  int m_tdc, m_rdc;
`endif
  bus_port_fifo #(.PCKG_SZ(W), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .bp(bp)
`ifdef BUS_PORT_FIFO_DROP_CNT_EN
    , .tx_drop_cnt(tx_drop_cnt), .rx_drop_cnt(rx_drop_cnt)
`endif
  );
  always #5 clk = ~clk;
  logic [W-1:0] txq[$], rxq[$];
  logic [1:0] m_ovf;
  int n_vec = 0, n_miss = 0;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic set_in(logic dp, logic [W-1:0] dd, logic p, logic pu, logic [W-1:0] pd, logic dpop);
    bp.dev_push = dp; bp.dev_d_in = dd; bp.pop = p; bp.push = pu; bp.D_push = pd; bp.dev_pop = dpop;
  endtask
  task automatic model_q(inout logic [W-1:0] q[$], input logic pu, input logic [W-1:0] d, input logic po, output logic dropped);
    dropped = 0;
    if (po && q.size() > 0) void'(q.pop_front());
    else if (pu && q.size() == D) dropped = 1;
    if (pu && !dropped) q.push_back(d);
  endtask
  task automatic check_all();
    chk("pndng", 32'(bp.pndng), 32'(txq.size() > 0));
    chk("dev_full", 32'(bp.dev_full), 32'(txq.size() == D));
    chk("dev_pndng", 32'(bp.dev_pndng), 32'(rxq.size() > 0));
    chk("ovf", 32'(bp.ovf), 32'(m_ovf));
    if (txq.size() > 0) chk("D_pop", 32'(bp.D_pop), 32'(txq[0]));
    if (rxq.size() > 0) chk("dev_d_out", 32'(bp.dev_d_out), 32'(rxq[0]));
`ifdef BUS_PORT_FIFO_DROP_CNT_EN
    chk("tx_drop_cnt", 32'(tx_drop_cnt), 32'(m_tdc));
    chk("rx_drop_cnt", 32'(rx_drop_cnt), 32'(m_rdc));
`endif
  endtask
  task automatic cyc();
    logic dt, dr;
    @(posedge clk);
    if (!reset) begin
      txq.delete(); rxq.delete(); m_ovf = 0;
`ifdef BUS_PORT_FIFO_DROP_CNT_EN
      m_tdc = 0; m_rdc = 0;
`endif
    end else begin
      model_q(txq, bp.dev_push, bp.dev_d_in, bp.pop, dt);
      model_q(rxq, bp.push, bp.D_push, bp.dev_pop, dr);
      m_ovf = m_ovf | {dr, dt};
`ifdef BUS_PORT_FIFO_DROP_CNT_EN
      if (dt && m_tdc < 255) m_tdc++;
      if (dr && m_rdc < 255) m_rdc++;
`endif
    end
    #1 check_all();
    set_in(0, 0, 0, 0, 0, 0);
    reset = 1;
  endtask
  initial begin
    m_ovf = 0;
    set_in(0, 0, 0, 0, 0, 0);
    reset = 0;
    cyc();
    chk("rst_pndng", 32'(bp.pndng), 0);
    // reset mid-traffic with a pop in the reset cycle
    for (int i = 0; i < 3; i++) begin set_in(1, W'(16'h1000 + i), 0, 0, 0, 0); cyc(); end
    reset = 0; set_in(0, 0, 1, 0, 0, 0); cyc();
    chk("rst_mid_pndng", 32'(bp.pndng), 0);
    chk("rst_mid_ovf", 32'(bp.ovf), 0);
    cyc();
    chk("post_rst_pndng", 32'(bp.pndng), 0);
    // TX FWFT order
    set_in(1, 16'h0101, 0, 0, 0, 0); cyc();
    chk("fwft_lat", 32'(bp.D_pop), 32'h0101);
    set_in(1, 16'h0202, 0, 0, 0, 0); cyc();
    set_in(1, 16'h0303, 0, 0, 0, 0); cyc();
    for (int i = 0; i < 3; i++) begin
      chk("fwft_order", 32'(bp.D_pop), 32'(16'h0101 * (i + 1)));
      set_in(0, 0, 1, 0, 0, 0); cyc();
    end
    chk("fwft_empty", 32'(bp.pndng), 0);
    // TX full and overflow
    for (int i = 0; i < 9; i++) begin
      set_in(1, W'($urandom), 0, 0, 0, 0); cyc();
      if (i == 7) chk("full_after_8", 32'(bp.dev_full), 1);
    end
    chk("tx_ovf", 32'(bp.ovf[0]), 1);
`ifdef BUS_PORT_FIFO_DROP_CNT_EN
    chk("tx_drop_1", 32'(tx_drop_cnt), 1);
`endif
    // full boundary push+pop
    set_in(1, 16'hAAAA, 1, 0, 0, 0); cyc();
    chk("full_pp_full", 32'(bp.dev_full), 1);
    for (int i = 0; i < 7; i++) begin set_in(0, 0, 1, 0, 0, 0); cyc(); end
    chk("aaaa_last", 32'(bp.D_pop), 32'hAAAA);
    set_in(0, 0, 1, 0, 0, 0); cyc();
    // empty boundary on RX
    set_in(0, 0, 0, 1, 16'h05CC, 1); cyc();
    chk("rx_nobypass_pndng", 32'(bp.dev_pndng), 1);
    chk("rx_nobypass_data", 32'(bp.dev_d_out), 32'h05CC);
    set_in(0, 0, 0, 0, 0, 1); cyc();
    set_in(0, 0, 0, 0, 0, 1); cyc();
    chk("rx_empty_pop", 32'(bp.dev_pndng), 0);
    // RX wrap and saturation
    for (int i = 0; i < 300; i++) begin set_in(0, 0, 0, 1, W'($urandom), 0); cyc(); end
    chk("rx_ovf", 32'(bp.ovf[1]), 1);
`ifdef BUS_PORT_FIFO_DROP_CNT_EN
    chk("rx_sat", 32'(rx_drop_cnt), 255);
`endif
    for (int i = 0; i < 20; i++) begin set_in(0, 0, 0, i[0], W'($urandom), 1); cyc(); end
    for (int i = 0; i < 20; i++) begin set_in(0, 0, 0, 1, W'($urandom), 1); cyc(); end
    for (int i = 0; i < 10; i++) begin set_in(0, 0, 0, 0, 0, 1); cyc(); end
    // random traffic
    for (int i = 0; i < 600; i++) begin
      set_in(1'($urandom), W'($urandom), 1'($urandom), 1'($urandom), W'($urandom), ($urandom_range(3) == 0));
      reset = ($urandom_range(63) != 0);
      cyc();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
